kp_voice_alloc: RTL and testbench

//  Polyphonic voice allocator/scheduler for Karplus-Strong voices. Accepts note events (MIDI-derived)

---
 rtl/kp_voice_alloc.sv | 213 +++++++++++++++++++++
 tb/tb_kp_voice_alloc.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/kp_voice_alloc.sv
`default_nettype none
// kp_voice_alloc: assigns note events to NUM_VOICES Karplus-Strong voices, drives trig/velocity/delay.
// Optional feature: define KP_ALLOC_STEAL_EN to retrigger the oldest voice when every voice is busy.
module kp_voice_alloc #(
  parameter int NUM_VOICES = 4,
  parameter int TRIG_WIDTH = 8,
  parameter int VOICE_HOLD = 48000
) (
  input  logic                     a_clk,
  input  logic                     reset_n,
  input  logic                     ev_valid,
  output logic                     ev_ready,
  input  logic                     ev_note_on,
  input  logic [6:0]               ev_velocity,
  input  logic [9:0]               ev_delay,
  output logic [NUM_VOICES-1:0]    voice_trig,
  output logic [7*NUM_VOICES-1:0]  voice_velocity,
  output logic [10*NUM_VOICES-1:0] voice_delay,
  output logic [NUM_VOICES-1:0]    busy_mask,
  output logic                     ev_drop
);

  localparam int              SEL_W    = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam int              CNT_W    = $clog2(TRIG_WIDTH) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TRIG_WIDTH - 1);
  localparam logic [15:0]     HOLD     = 16'(VOICE_HOLD);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SCAN = 2'd1;
  localparam logic [1:0] S_FIRE = 2'd2;
  localparam logic [1:0] S_GAP  = 2'd3;

  logic [1:0]            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  ev_ready_q, ev_ready_d;
  logic [NUM_VOICES-1:0] trig_q, trig_d;
  logic [NUM_VOICES-1:0] busy_q, busy_d;
  logic [SEL_W-1:0]      sel_q, sel_d;
  logic                  lat_on_q, lat_on_d;
  logic [6:0]            lat_vel_q, lat_vel_d;
  logic [9:0]            lat_delay_q, lat_delay_d;
  logic [6:0]            vel_q [NUM_VOICES];
  logic [6:0]            vel_d [NUM_VOICES];
  logic [9:0]            dly_q [NUM_VOICES];
  logic [9:0]            dly_d [NUM_VOICES];
  logic [15:0]           age_q [NUM_VOICES];
  logic [15:0]           age_d [NUM_VOICES];

  logic                  accept;
  logic                  load_en;
  logic                  can_load;
  logic                  any_free;
  logic [SEL_W-1:0]      free_idx;
  logic [SEL_W-1:0]      pick_idx;

  assign accept = ev_valid && ev_ready_q;

  always_comb begin
    any_free = 1'b0;
    free_idx = '0;
    for (int i = NUM_VOICES - 1; i >= 0; i--) begin
      if (!busy_q[i]) begin
        any_free = 1'b1;
        free_idx = SEL_W'(i);
      end
    end
  end

`ifdef KP_ALLOC_STEAL_EN
  logic [SEL_W-1:0] steal_idx;
  logic [15:0]      best_age;

  // Strict greater-than keeps ties on the lowest index.
  always_comb begin
    steal_idx = '0;
    best_age  = age_q[0];
    for (int i = 1; i < NUM_VOICES; i++) begin
      if (age_q[i] > best_age) begin
        best_age  = age_q[i];
        steal_idx = SEL_W'(i);
      end
    end
  end

  assign can_load = 1'b1;
  assign pick_idx = any_free ? free_idx : steal_idx;
`else
  assign can_load = any_free;
  assign pick_idx = free_idx;
`endif

  // State register and all datapath flops
  always_ff @(posedge a_clk) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      ev_ready_q  <= 1'b0;
      trig_q      <= '0;
      busy_q      <= '0;
      sel_q       <= '0;
      lat_on_q    <= 1'b0;
      lat_vel_q   <= '0;
      lat_delay_q <= 10'd2;
      for (int i = 0; i < NUM_VOICES; i++) begin
        vel_q[i] <= '0;
        dly_q[i] <= 10'd512;
        age_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ev_ready_q  <= ev_ready_d;
      trig_q      <= trig_d;
      busy_q      <= busy_d;
      sel_q       <= sel_d;
      lat_on_q    <= lat_on_d;
      lat_vel_q   <= lat_vel_d;
      lat_delay_q <= lat_delay_d;
      for (int i = 0; i < NUM_VOICES; i++) begin
        vel_q[i] <= vel_d[i];
        dly_q[i] <= dly_d[i];
        age_q[i] <= age_d[i];
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (accept) state_d = S_SCAN;
      end
      S_SCAN: begin
        cnt_d   = '0;
        state_d = (lat_on_q && can_load) ? S_FIRE : S_IDLE;
      end
      S_FIRE: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = S_GAP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_GAP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered one cycle behind the state, so ready only
  // reasserts after a full cycle spent in IDLE.
  always_comb begin
    ev_ready_d = (state_d == S_IDLE) && (state_q == S_IDLE);
    for (int i = 0; i < NUM_VOICES; i++) begin
      trig_d[i] = (state_q == S_FIRE) && (sel_q == SEL_W'(i));
    end
    load_en = (state_q == S_SCAN) && lat_on_q && can_load;
    ev_drop = (state_q == S_SCAN) && lat_on_q && !can_load;
  end

  // Event latch and per-voice registers
  always_comb begin
    lat_on_d    = lat_on_q;
    lat_vel_d   = lat_vel_q;
    lat_delay_d = lat_delay_q;
    if (accept) begin
      lat_on_d    = ev_note_on && (ev_velocity != 7'd0);
      lat_vel_d   = ev_velocity;
      lat_delay_d = (ev_delay < 10'd2) ? 10'd2 : ev_delay;
    end
    sel_d = load_en ? pick_idx : sel_q;
    for (int i = 0; i < NUM_VOICES; i++) begin
      vel_d[i]  = vel_q[i];
      dly_d[i]  = dly_q[i];
      age_d[i]  = age_q[i];
      busy_d[i] = busy_q[i];
      if (busy_q[i]) begin
        if (age_q[i] != 16'hFFFF) age_d[i] = age_q[i] + 16'd1;
        if (age_d[i] == HOLD) busy_d[i] = 1'b0;
      end
      if ((state_q == S_SCAN) && !lat_on_q && (dly_q[i] == lat_delay_q)) busy_d[i] = 1'b0;
      // A fresh load overrides both expiry and note-off in the same cycle.
      if (load_en && (pick_idx == SEL_W'(i))) begin
        vel_d[i]  = lat_vel_q;
        dly_d[i]  = lat_delay_q;
        age_d[i]  = '0;
        busy_d[i] = 1'b1;
      end
    end
  end

  assign ev_ready   = ev_ready_q;
  assign voice_trig = trig_q;
  assign busy_mask  = busy_q;

  generate
    for (genvar g = 0; g < NUM_VOICES; g++) begin : g_pack
      assign voice_velocity[7*g +: 7]  = vel_q[g];
      assign voice_delay[10*g +: 10]   = dly_q[g];
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_kp_voice_alloc.sv
`default_nettype none
// tb_kp_voice_alloc: scoreboard bench; expected triggers/drops queued at send, compared on DUT output.
module tb_kp_voice_alloc;

  localparam int NV = 4;

  logic            a_clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            ev_valid = 1'b0;
  logic            ev_ready;
  logic            ev_note_on = 1'b0;
  logic [6:0]      ev_velocity = '0;
  logic [9:0]      ev_delay = '0;
  logic [NV-1:0]   voice_trig;
  logic [7*NV-1:0] voice_velocity;
  logic [10*NV-1:0] voice_delay;
  logic [NV-1:0]   busy_mask;
  logic            ev_drop;

  kp_voice_alloc #(.NUM_VOICES(NV), .TRIG_WIDTH(4), .VOICE_HOLD(100)) dut (
    .a_clk(a_clk), .reset_n(reset_n),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_note_on(ev_note_on),
    .ev_velocity(ev_velocity), .ev_delay(ev_delay),
    .voice_trig(voice_trig), .voice_velocity(voice_velocity), .voice_delay(voice_delay),
    .busy_mask(busy_mask), .ev_drop(ev_drop)
  );

  always #5 a_clk = ~a_clk;

  typedef struct {
    bit         drop;
    int         voice;
    logic [6:0] vel;
    logic [9:0] dly;
  } exp_t;

  exp_t          sb[$];
  int            errors = 0;
  int            checks = 0;
  int            overlap_cnt = 0;
  logic [NV-1:0] prev_trig = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic void push_trig(input int v, input logic [6:0] vel, input logic [9:0] dly);
    exp_t e;
    e.drop = 1'b0; e.voice = v; e.vel = vel; e.dly = dly;
    sb.push_back(e);
  endfunction

  function automatic void push_drop();
    exp_t e;
    e.drop = 1'b1; e.voice = 0; e.vel = '0; e.dly = '0;
    sb.push_back(e);
  endfunction

  // Output monitor: pops one expectation per trig rise or drop pulse.
  always @(negedge a_clk) begin
    exp_t e;
    if (reset_n) begin
      if ($countones(voice_trig) > 1) overlap_cnt++;
      if (voice_trig != '0 && prev_trig == '0) begin
        if (sb.size() == 0) begin
          check("trig_unexpected", voice_trig, 0);
        end else begin
          e = sb.pop_front();
          check("trig_kind_is_drop", 0, e.drop);
          if (!e.drop) begin
            check("trig_voice", voice_trig, 64'(1) << e.voice);
            check("trig_velocity", (voice_velocity >> (7*e.voice)) & 7'h7f, e.vel);
            check("trig_delay", (voice_delay >> (10*e.voice)) & 10'h3ff, e.dly);
          end
        end
      end
      if (ev_drop) begin
        if (sb.size() == 0) begin
          check("drop_unexpected", 1, 0);
        end else begin
          e = sb.pop_front();
          check("drop_kind", 1, e.drop);
        end
      end
    end
    prev_trig = voice_trig;
  end

  task automatic wait_ready();
    int n = 0;
    while (!ev_ready && n < 60) begin
      @(negedge a_clk);
      n++;
    end
    if (!ev_ready) check("ready_timeout", 0, 1);
  endtask

  // Called at a negedge; returns at the negedge right after the accepting edge.
  task automatic send(input logic on, input logic [6:0] vel, input logic [9:0] dly);
    wait_ready();
    ev_valid = 1'b1; ev_note_on = on; ev_velocity = vel; ev_delay = dly;
    @(posedge a_clk);
    @(negedge a_clk);
    ev_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge a_clk);
    reset_n = 1'b0;
    repeat (2) @(negedge a_clk);
    reset_n = 1'b1;
    @(negedge a_clk);
  endtask

  initial begin
    // Reset values
    repeat (2) @(negedge a_clk);
    check("rst_ready", ev_ready, 0);
    check("rst_trig", voice_trig, 0);
    check("rst_busy", busy_mask, 0);
    check("rst_drop", ev_drop, 0);
    check("rst_vel", voice_velocity, 0);
    check("rst_delay", voice_delay, {4{10'd512}});
    reset_n = 1'b1;
    @(negedge a_clk);
    check("ready_after_release", ev_ready, 1);

    // 1: single note-on timing
    push_trig(0, 7'd100, 10'd300);
    send(1'b1, 7'd100, 10'd300);
    check("t1_ready_scan", ev_ready, 0);
    @(negedge a_clk);
    check("t1_trig_n1", voice_trig, 0);
    check("t1_busy", busy_mask, 4'b0001);
    @(negedge a_clk);
    check("t1_trig_n2", voice_trig, 4'b0001);
    repeat (3) @(negedge a_clk);
    check("t1_trig_n5", voice_trig, 4'b0001);
    @(negedge a_clk);
    check("t1_trig_n6", voice_trig, 0);
    repeat (3) @(negedge a_clk);
    check("t1_ready_n9", ev_ready, 0);
    @(negedge a_clk);
    check("t1_ready_n10", ev_ready, 1);

    // 2: four back-to-back note-ons fill voices in order
    do_reset();
    for (int i = 0; i < 4; i++) begin
      push_trig(i, 7'(10 + i), 10'(100 * (i + 1)));
      send(1'b1, 7'(10 + i), 10'(100 * (i + 1)));
    end
    wait_ready();
    check("t2_busy", busy_mask, 4'b1111);
    check("t2_delays", voice_delay, {10'd400, 10'd300, 10'd200, 10'd100});

    // 3: fifth note-on with every voice busy
`ifdef KP_ALLOC_STEAL_EN
    push_trig(0, 7'd90, 10'd500);
    send(1'b1, 7'd90, 10'd500);
    wait_ready();
    check("t3_steal_delay", voice_delay, {10'd400, 10'd300, 10'd200, 10'd500});
    check("t3_steal_busy", busy_mask, 4'b1111);
`else
    push_drop();
    send(1'b1, 7'd90, 10'd500);
    @(negedge a_clk);
    check("t3_drop_ready_n1", ev_ready, 0);
    @(negedge a_clk);
    check("t3_drop_ready_n2", ev_ready, 1);
    check("t3_drop_delays", voice_delay, {10'd400, 10'd300, 10'd200, 10'd100});
    check("t3_drop_vel", voice_velocity, {7'd13, 7'd12, 7'd11, 7'd10});
    check("t3_drop_busy", busy_mask, 4'b1111);
`endif

    // 4: note-off by note_on=0 and by velocity 0
    do_reset();
    push_trig(0, 7'd20, 10'd100);
    send(1'b1, 7'd20, 10'd100);
    push_trig(1, 7'd21, 10'd200);
    send(1'b1, 7'd21, 10'd200);
    wait_ready();
    send(1'b0, 7'd50, 10'd200);
    @(negedge a_clk);
    check("t4_off_busy", busy_mask, 4'b0001);
    check("t4_off_ready_n1", ev_ready, 0);
    @(negedge a_clk);
    check("t4_off_ready_n2", ev_ready, 1);
    push_trig(1, 7'd22, 10'd200);
    send(1'b1, 7'd22, 10'd200);
    wait_ready();
    check("t4_reload_busy", busy_mask, 4'b0011);
    send(1'b1, 7'd0, 10'd200);
    @(negedge a_clk);
    check("t4_vel0_busy", busy_mask, 4'b0001);
    @(negedge a_clk);
    check("t4_vel0_ready", ev_ready, 1);
    send(1'b0, 7'd1, 10'd777);
    repeat (2) @(negedge a_clk);
    check("t4_nomatch_busy", busy_mask, 4'b0001);

    // 5: hold expiry and delay clamp
    do_reset();
    push_trig(0, 7'd70, 10'd300);
    send(1'b1, 7'd70, 10'd300);
    repeat (100) @(negedge a_clk);
    check("t5_busy_before_hold", busy_mask, 4'b0001);
    @(negedge a_clk);
    check("t5_busy_after_hold", busy_mask, 4'b0000);
    push_trig(0, 7'd5, 10'd2);
    send(1'b1, 7'd5, 10'd1);
    wait_ready();
    check("t5_clamp_delay", voice_delay[9:0], 10'd2);

    // 6: reset during FIRE
    do_reset();
    push_trig(0, 7'd33, 10'd123);
    send(1'b1, 7'd33, 10'd123);
    repeat (3) @(negedge a_clk);
    reset_n = 1'b0;
    @(negedge a_clk);
    check("t6_rst_trig", voice_trig, 0);
    check("t6_rst_busy", busy_mask, 0);
    check("t6_rst_delay", voice_delay, {4{10'd512}});
    check("t6_rst_ready", ev_ready, 0);
    reset_n = 1'b1;
    @(negedge a_clk);
    push_trig(0, 7'd44, 10'd321);
    send(1'b1, 7'd44, 10'd321);
    wait_ready();
    check("t6_after_busy", busy_mask, 4'b0001);

    repeat (5) @(negedge a_clk);
    check("sb_empty", sb.size(), 0);
    check("trig_onehot", overlap_cnt, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
